cam_array: RTL and testbench

CAM_ARRAY -- requirements
Module: cam_array

---
 rtl/cam_pkg.sv | 6 +
 rtl/cam_array_encoder.sv | 18 +
 rtl/cam_array.sv | 71 +++++++
 tb/tb_cam_array.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared defaults and write-FSM encoding for the CAM
package cam_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 4;
  typedef enum logic {IDLE, WRITE} wr_state_t;
endpackage

// File: rtl/cam_array_encoder.sv
// cam_array_encoder: priority encoder, one-hot/any-hot vector to index with valid flag
module cam_array_encoder #(
  parameter int WIDTH = 16,
  parameter string LSB_PRIORITY = "HIGH"
) (
  input  logic [WIDTH-1:0]         input_unencoded,
  output logic                     output_valid,
  output logic [$clog2(WIDTH)-1:0] output_encoded
);
  localparam int W = $clog2(WIDTH);
  localparam bit LSB = LSB_PRIORITY == "HIGH";
  assign output_valid = |input_unencoded;
  always_comb begin
    output_encoded = '0;
    for (int i = 0; i < WIDTH; i++)
      if (input_unencoded[LSB ? WIDTH-1-i : i]) output_encoded = W'(LSB ? WIDTH-1-i : i);
  end
endmodule

// File: rtl/cam_array.sv
// cam_array: content-addressable memory with registered write FSM and 2-stage search pipeline
module cam_array
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    write_addr,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     write_delete,
  input  logic                     write_enable,
  output logic                     write_busy,
  input  logic [DATA_WIDTH-1:0]    compare_data,
  input  logic                     compare_valid,
  output logic                     compare_ready,
  output logic                     match_valid,
  output logic [2**ADDR_WIDTH-1:0] match_many,
  output logic                     match,
  output logic [ADDR_WIDTH-1:0]    match_addr,
  output logic                     match_multi
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  wr_state_t state;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic wdel;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] hit;
  logic s1_valid;
  logic [DATA_WIDTH-1:0] key;
  assign write_busy = state == WRITE;
  assign compare_ready = state == IDLE && !write_enable;
  assign match_multi = |(match_many & (match_many - DEPTH'(1)));
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) hit[i] = valid[i] && mem[i] == key;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      s1_valid <= 1'b0;
      match_valid <= 1'b0;
      match_many <= '0;
    end else begin
      if (state == IDLE && write_enable) begin
        state <= WRITE;
        wa <= write_addr;
        wd <= write_data;
        wdel <= write_delete;
      end else if (state == WRITE) begin
        state <= IDLE;
        valid[wa] <= !wdel;
      end
      s1_valid <= compare_valid && compare_ready;
      if (compare_valid && compare_ready) key <= compare_data;
      match_valid <= s1_valid;
      if (s1_valid) match_many <= hit;
    end
  end
  always_ff @(posedge clk)
    if (!rst && state == WRITE && !wdel) mem[wa] <= wd;
  cam_array_encoder #(.WIDTH(DEPTH), .LSB_PRIORITY("HIGH")) u_enc (
    .input_unencoded(match_many),
    .output_valid(match),
    .output_encoded(match_addr)
  );
endmodule

// File: tb/tb_cam_array.sv
// tb_cam_array: directed scoreboard bench for cam_array
module tb_cam_array;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] write_addr = '0;
  logic [15:0] write_data = '0;
  logic write_delete = 0;
  logic write_enable = 0;
  logic write_busy;
  logic [15:0] compare_data = '0;
  logic compare_valid = 0;
  logic compare_ready;
  logic match_valid;
  logic [15:0] match_many;
  logic match;
  logic [3:0] match_addr;
  logic match_multi;
  typedef struct {logic m; logic [3:0] a; logic [15:0] many; logic mu;} exp_t;
  exp_t sbq[$];
  int pulse_cyc[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int pulses = 0;
  cam_array #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .write_addr(write_addr), .write_data(write_data), .write_delete(write_delete),
    .write_enable(write_enable), .write_busy(write_busy),
    .compare_data(compare_data), .compare_valid(compare_valid), .compare_ready(compare_ready),
    .match_valid(match_valid), .match_many(match_many), .match(match),
    .match_addr(match_addr), .match_multi(match_multi)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && match_valid === 1'b1) begin
      exp_t e;
      pulses++;
      pulse_cyc.push_back(cycle);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_match_valid: got pulse expected none");
      end else begin
        e = sbq.pop_front();
        chk("match", 32'(match), 32'(e.m));
        chk("match_addr", 32'(match_addr), 32'(e.a));
        chk("match_many", 32'(match_many), 32'(e.many));
        chk("match_multi", 32'(match_multi), 32'(e.mu));
      end
    end
  end
  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic del);
    int n = 0;
    @(negedge clk);
    while (write_busy && n < 20) begin @(negedge clk); n++; end
    write_addr = a; write_data = d; write_delete = del; write_enable = 1;
    @(negedge clk);
    write_enable = 0; write_addr = 4'hF; write_data = 16'h5555; write_delete = ~del;
    chk("write_busy_set", 32'(write_busy), 1);
    @(negedge clk);
    chk("write_busy_clr", 32'(write_busy), 0);
  endtask
  task automatic do_compare(input logic [15:0] k, input logic m, input logic [3:0] a,
                            input logic [15:0] many, input logic mu);
    int n = 0;
    @(negedge clk);
    compare_data = k; compare_valid = 1;
    while (!compare_ready && n < 20) begin @(negedge clk); n++; end
    if (!compare_ready) begin
      checks++; errors++;
      $display("FAIL compare_accept_timeout: got ready=0 expected 1");
      compare_valid = 0;
    end else begin
      sbq.push_back('{m, a, many, mu});
      @(posedge clk); #1 compare_valid = 0;
    end
  endtask
  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("scoreboard_drain", 32'(sbq.size()), 0);
  endtask
  initial begin
    logic [15:0] keys [4];
    int p0;
    keys = '{16'hBEEF, 16'h0001, 16'hBEEF, 16'h0001};
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_write_busy", 32'(write_busy), 0);
    chk("rst_match_valid", 32'(match_valid), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_match_addr", 32'(match_addr), 0);
    chk("rst_match_many", 32'(match_many), 0);
    chk("rst_match_multi", 32'(match_multi), 0);
    chk("rst_compare_ready", 32'(compare_ready), 1);
    do_compare(16'h0000, 0, 0, 16'h0000, 0);
    drain();
    do_write(3, 16'hBEEF, 0);
    do_compare(16'hBEEF, 1, 3, 16'h0008, 0);
    drain();
    do_write(9, 16'h1234, 0);
    do_write(5, 16'h1234, 0);
    do_compare(16'h1234, 1, 5, 16'h0220, 1);
    do_write(5, 16'h0000, 1);
    do_compare(16'h1234, 1, 9, 16'h0200, 0);
    drain();
    @(negedge clk);
    write_addr = 7; write_data = 16'hCAFE; write_delete = 0; write_enable = 1;
    compare_data = 16'hCAFE; compare_valid = 1;
    #1 chk("same_cycle_ready", 32'(compare_ready), 0);
    @(negedge clk);
    write_enable = 0; write_data = 16'h0000;
    chk("same_cycle_busy", 32'(write_busy), 1);
    chk("write_state_ready", 32'(compare_ready), 0);
    @(negedge clk);
    chk("after_write_ready", 32'(compare_ready), 1);
    sbq.push_back('{1'b1, 4'd7, 16'h0080, 1'b0});
    @(posedge clk); #1 compare_valid = 0;
    drain();
    @(negedge clk);
    compare_valid = 1;
    for (int i = 0; i < 4; i++) begin
      compare_data = keys[i];
      if (keys[i] == 16'hBEEF) sbq.push_back('{1'b1, 4'd3, 16'h0008, 1'b0});
      else sbq.push_back('{1'b0, 4'd0, 16'h0000, 1'b0});
      @(posedge clk); #1;
    end
    compare_valid = 0;
    drain();
    if (pulse_cyc.size() >= 4)
      for (int i = 1; i < 4; i++)
        chk("b2b_consecutive", 32'(pulse_cyc[pulse_cyc.size()-4+i] - pulse_cyc[pulse_cyc.size()-5+i]), 1);
    else chk("b2b_pulse_count", 32'(pulse_cyc.size()), 4);
    @(negedge clk);
    compare_data = 16'hBEEF; compare_valid = 1;
    @(posedge clk); #1 compare_valid = 0;
    p0 = pulses;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    repeat (4) @(negedge clk);
    chk("no_pulse_after_rst", 32'(pulses), 32'(p0));
    chk("post_rst_match_many", 32'(match_many), 0);
    do_compare(16'hBEEF, 0, 0, 16'h0000, 0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
